// File: rtl/encrypt_feeder_if.sv
// Word stream interface used on both sides of the encrypt feeder.
// Handshake: a word moves on a rising clock edge where valid and ready are
// both 1. Once the master raises valid it keeps valid and data stable until
// that transfer. ready may change freely and never depends on valid in the
// same cycle.
interface encrypt_feeder_if #(
  parameter int W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/encrypt_feeder.sv
// Collects plaintext words into one block, hands the block and the held key
// to an external encrypt core, waits (with a timeout) for the core, then
// streams the ciphertext back out one word at a time, first word = MSW.
// Only one block is in flight; input is refused from START until DRAIN ends.
// BLOCK_W must be a whole multiple of WORD_W.
module encrypt_feeder #(
  parameter int WORD_W         = 32,
  parameter int BLOCK_W        = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLOCK_W-1:0] key_in,
  input  logic               key_we,
  encrypt_feeder_if.slave    s,
  output logic               enc_start,
  input  logic               enc_finished,
  output logic [BLOCK_W-1:0] enc_plaintext,
  output logic [BLOCK_W-1:0] enc_key,
  input  logic [BLOCK_W-1:0] enc_ciphertext,
  encrypt_feeder_if.master   m,
  output logic               busy,
  output logic               timeout_err,
  output logic [1:0]         dbg_state
);

  localparam int NWORDS = BLOCK_W / WORD_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   in_cnt_q;
  logic [CNT_W-1:0]   out_cnt_q;
  logic [TMO_W-1:0]   wait_cnt_q;
  logic [BLOCK_W-1:0] pt_q;
  logic [BLOCK_W-1:0] pt_d;
  logic [BLOCK_W-1:0] key_q;
  logic [BLOCK_W-1:0] out_q;
  logic               tmo_err_q;
  logic               s_ready_q;
  logic               enc_start_q;
  logic               m_valid_q;
  logic               busy_q;

  // Plaintext with the incoming word dropped into the slot of the current word index.
  always_comb begin
    pt_d = pt_q;
    for (int k = 0; k < NWORDS; k++) begin
      if (in_cnt_q == CNT_W'(k)) begin
        pt_d[BLOCK_W-1-k*WORD_W -: WORD_W] = s.data;
      end
    end
  end

  // Control FSM with registered handshake/status outputs and the datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      pt_q        <= '0;
      key_q       <= '0;
      out_q       <= '0;
      tmo_err_q   <= 1'b0;
      s_ready_q   <= 1'b1;
      enc_start_q <= 1'b0;
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (key_we) key_q <= key_in;
          if (s.valid) begin
            pt_q <= pt_d;
            if (in_cnt_q == LAST_WORD) begin
              in_cnt_q    <= '0;
              state_q     <= ST_START;
              s_ready_q   <= 1'b0;
              enc_start_q <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              in_cnt_q <= in_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_START: begin
          // Single-cycle start pulse; the timeout count begins fresh for this block.
          enc_start_q <= 1'b0;
          wait_cnt_q  <= '0;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          // A finish on the final allowed cycle still counts as success.
          if (enc_finished) begin
            out_q     <= enc_ciphertext;
            out_cnt_q <= '0;
            m_valid_q <= 1'b1;
            state_q   <= ST_DRAIN;
          end else if (wait_cnt_q == TMO_LAST) begin
            tmo_err_q <= 1'b1;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_COLLECT;
          end else begin
            wait_cnt_q <= wait_cnt_q + TMO_W'(1);
          end
        end
        ST_DRAIN: begin
          if (key_we) key_q <= key_in;
          if (m.ready) begin
            // Shifting keeps the next word at the top of the register.
            out_q <= out_q << WORD_W;
            if (out_cnt_q == LAST_WORD) begin
              out_cnt_q <= '0;
              m_valid_q <= 1'b0;
              s_ready_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= ST_COLLECT;
            end else begin
              out_cnt_q <= out_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q     <= ST_COLLECT;
          s_ready_q   <= 1'b1;
          enc_start_q <= 1'b0;
          m_valid_q   <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign s.ready       = s_ready_q;
  assign m.valid       = m_valid_q;
  assign m.data        = out_q[BLOCK_W-1 -: WORD_W];
  assign enc_start     = enc_start_q;
  assign enc_plaintext = pt_q;
  assign enc_key       = key_q;
  assign busy          = busy_q;
  assign timeout_err   = tmo_err_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/encrypt_feeder.md
ENCRYPT_FEEDER -- requirements
Module: encrypt_feeder

Interface
REQ-001 Parameter WORD_W, 32, width of streaming input/output words; BLOCK_W / WORD_W SHALL be an integer.
REQ-002 Parameter BLOCK_W, 128, block and key width, equal to `KEY_SIZE.
REQ-003 Parameter TIMEOUT_CYCLES, 1024, maximum cycles to wait for enc_finished.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-006 key_in  in  BLOCK_W  cipher key, captured on key_we.
REQ-007 key_we  in  1  key write strobe.
REQ-008 s_valid / s_ready / s_data  in / out / in  1 / 1 / WORD_W  plaintext word stream.
REQ-009 enc_start  out  1  start to encrypt core.
REQ-010 enc_finished  in  1  finished from encrypt core.
REQ-011 enc_plaintext  out  BLOCK_W  assembled plaintext to core.
REQ-012 enc_key  out  BLOCK_W  held key to core.
REQ-013 enc_ciphertext  in  BLOCK_W  ciphertext from core.
REQ-014 m_valid / m_ready / m_data  out / in / out  1 / 1 / WORD_W  ciphertext word stream.
REQ-015 busy  out  1  high in any state other than COLLECT.
REQ-016 timeout_err  out  1  sticky timeout flag.

Function
REQ-017 FSM states SHALL be COLLECT, START, WAIT, DRAIN; s_ready SHALL be 1 only in COLLECT; m_valid SHALL be 1 only in DRAIN.
REQ-018 A word transfers when s_valid and s_ready are both 1; word k (k = 0 first) SHALL be written to enc_plaintext bits [BLOCK_W-1-k*WORD_W -: WORD_W] (first word is the MSW).
REQ-019 On the cycle the last word (k = BLOCK_W/WORD_W-1) transfers, the FSM SHALL go COLLECT->START and the word counter SHALL wrap to 0.
REQ-020 START SHALL last exactly one cycle with enc_start = 1, then go to WAIT; enc_start SHALL be 0 in all other states.
REQ-021 In WAIT, enc_plaintext and enc_key SHALL be held constant; when enc_finished = 1, enc_ciphertext SHALL be captured into the output register and the FSM SHALL go to DRAIN.
REQ-022 enc_finished SHALL be ignored outside WAIT (stale pulses after reset or timeout are discarded).
REQ-023 The WAIT cycle counter SHALL clear on entry to WAIT; when it reaches TIMEOUT_CYCLES without enc_finished, timeout_err SHALL set, the block SHALL be dropped, and the FSM SHALL go to COLLECT.
REQ-024 If enc_finished = 1 on the timeout cycle, finished SHALL win; no error is flagged.
REQ-025 In DRAIN, m_data SHALL present ciphertext words MSW first; the word advances on m_valid & m_ready; m_data SHALL stay stable while m_ready = 0; after the last word transfers, the FSM SHALL go to COLLECT.
REQ-026 key_we SHALL load key_in into enc_key in COLLECT and DRAIN; it SHALL be ignored in START and WAIT.
REQ-027 Latency: last input word accepted at cycle N -> enc_start = 1 at N+1; enc_finished sampled at cycle M -> m_valid = 1 at M+1.
REQ-028 Blocks SHALL NOT overlap: no input is accepted from START until DRAIN completes.

Reset
REQ-029 While rst_n = 0 at posedge, the FSM SHALL go to COLLECT and the word counters and WAIT counter SHALL clear.
REQ-030 On reset, enc_plaintext, enc_key, the output register and timeout_err SHALL clear to 0; enc_start and m_valid SHALL be 0.
REQ-031 Reset mid-operation (any state) SHALL abort the block without output; timeout_err SHALL be cleared only by reset.

Verification
REQ-032 Round trip:
- key_we with key 0x0f0e0d0c0b0a09080706050403020100;
- stream words 0x6c617669, 0x76716520, 0x74692065, 0x64616d20;
- core model returns 0xa65d9851797832657860fedf5c570d18 after 40 cycles;
- required: m_data words a65d9851, 79783265, 7860fedf, 5c570d18 in that order, and enc_start high for exactly one cycle.
REQ-033 Output backpressure: hold m_ready = 0 for 10 cycles in DRAIN -> m_valid stays 1, m_data stays 0xa65d9851, s_ready stays 0.
REQ-034 Timeout: core never asserts finished -> timeout_err = 1 exactly TIMEOUT_CYCLES cycles after WAIT entry, FSM returns to COLLECT, m_valid never rises.
REQ-035 Reset during WAIT, then a stale enc_finished pulse 5 cycles later -> pulse ignored, m_valid stays 0, s_ready = 1, all outputs 0.
REQ-036 key_we asserted during WAIT with key 0xFF..FF -> enc_key unchanged; key_we in DRAIN with the same value -> enc_key = 0xFF..FF on the next cycle.
